adc_conversion_scheduler: RTL and testbench
===========================================

# adc_conversion_scheduler

Sequencer between the host-side register logic and the SAR-ADC digital core. It holds the core in reset while idle, latches averaging/OSR configuration at start, and releases the core for a single burst of N results or for continuous conversion. It discards settling results after each release and buffers accepted results in a small FIFO with a valid/ready handshake toward the host.

## Interface
Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16
- DISCARD, 1, results dropped after each core release (0..3) to flush the OSR/averaging pipeline

Ports:
- clk  in  1  digital clock; same clock as the core's clk_dig_in
- rst_n  in  1  asynchronous active-low reset
- start_in  in  1  single-cycle start request; honoured only in IDLE
- stop_in  in  1  level/pulse; ends a burst or continuous run
- continuous_in  in  1  sampled at start: 1 = run until stop_in, 0 = burst
- count_in  in  8  burst length in results, sampled at start; 0 means 256
- avg_control_in  in  3  averaging setting, sampled at start
- osr_mode_in  in  3  oversampling setting, sampled at start
- config_1_out  out  16  to core config_1_in: {10'b0, osr_mode, avg_control}
- core_rst_n_out  out  1  to core rst_n; 0 holds the core in reset
- conv_finished_in  in  1  core conversion-finished strobe (one cycle per result)
- result_in  in  16  core result; valid in the cycle of conv_finished_in
- result_out  out  16  FIFO head
- result_valid_out  out  1  FIFO non-empty
- result_ready_in  in  1  host pop; pop happens when valid and ready
- fifo_level_out  out  5  current entry count, 0..FIFO_DEPTH
- busy_out  out  1  1 in any state except IDLE
- overflow_out  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- States: IDLE, SETTLE, RUN, STOP.
- IDLE: core_rst_n_out=0. start_in -> latch config, continuous, count (0->256) and clear overflow_out; go SETTLE if DISCARD>0, else RUN.
- SETTLE: core_rst_n_out=1; each conv_finished_in increments the discard counter; after DISCARD strobes go RUN. Results are not stored.
- RUN: each conv_finished_in pushes result_in (or drops it if the FIFO cannot accept). A dropped result sets overflow_out and still counts toward the burst. In burst mode, the remaining count decrements per strobe; at the strobe taking it to 0 go STOP.
- stop_in in SETTLE or RUN -> STOP. A strobe coinciding with stop_in in RUN is still pushed.
- STOP: core_rst_n_out=0 for exactly one cycle, then IDLE.
- start_in outside IDLE is ignored. stop_in in IDLE/STOP is ignored.
- FIFO: push when a RUN strobe arrives and (level<FIFO_DEPTH or pop in the same cycle). Push and pop in the same cycle leave the level unchanged. Pop when empty has no effect. Pointers wrap modulo FIFO_DEPTH. FIFO contents survive STOP/IDLE until popped; they are cleared only by rst_n.
- config_1_out changes only at the accepted start edge, while the core is still in reset.

## Timing
- Reset values: config_1_out=0, core_rst_n_out=0, result_valid_out=0, result_out=0, fifo_level_out=0, busy_out=0, overflow_out=0; state IDLE; counters 0.
- All outputs are registered.
- start_in sampled at edge k -> core_rst_n_out=1, busy_out=1 and config_1_out updated from edge k.
- A RUN strobe at edge k -> result_valid_out=1 and the level is updated from edge k. A push into an empty FIFO appears on result_out after 1 cycle.
- Final burst strobe at edge k -> STOP after k; core_rst_n_out=0 after k; IDLE (busy_out=0) after k+1.
- Asserting rst_n mid-run clears everything immediately, including the FIFO, and drives core_rst_n_out=0.

## Test plan
- Burst: DISCARD=1, count_in=3, avg=2, osr=5, host ready=1; core strobes results 0x100..0x103 -> 0x100 discarded; 0x101, 0x102, 0x103 delivered; config_1_out=0x002A; core_rst_n_out low 1 cycle after the last strobe; busy_out falls the next cycle.
- count_in=0 -> exactly 256 accepted strobes before STOP.
- Overflow: FIFO_DEPTH=4, ready=0, count_in=6 -> level 4, overflow_out=1. Then ready=1 -> first 4 results popped in order; no 5th/6th result.
- Full FIFO with push and pop in the same cycle -> level stays 4, no overflow, order preserved.
- Continuous mode with stop_in coinciding with a strobe -> that result is stored, STOP follows, start_in during STOP is ignored.
- rst_n asserted while in RUN with a FIFO level of 2 -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/adc_conversion_scheduler.sv
// Sequencer between the host register logic and the SAR-ADC digital core.
// It gates the core reset, discards settling results and buffers the rest in a small FIFO.
module adc_conversion_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        continuous_in,
  input  logic [7:0]  count_in,
  input  logic [2:0]  avg_control_in,
  input  logic [2:0]  osr_mode_in,
  output logic [15:0] config_1_out,
  output logic        core_rst_n_out,
  input  logic        conv_finished_in,
  input  logic [15:0] result_in,
  output logic [15:0] result_out,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic [4:0]  fifo_level_out,
  output logic        busy_out,
  output logic        overflow_out
);

  // state  | meaning
  // IDLE   | core held in reset, waiting for start_in
  // SETTLE | core released, dropping DISCARD settling results
  // RUN    | core released, results pushed into the FIFO
  // STOP   | core back in reset for one cycle before IDLE

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L   = 5'(FIFO_DEPTH);
  localparam logic [1:0] DISC_LAST = 2'(DISCARD - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, STOP} state_t;

  state_t        state;
  logic          continuous;
  logic [8:0]    remaining;
  logic [1:0]    discard_cnt;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [4:0]    level_nxt;
  logic [15:0]   head_nxt;
  logic          run_strobe;
  logic          push;
  logic          pop;

  assign run_strobe = (state == RUN) && conv_finished_in;
  assign pop        = result_valid_out && result_ready_in;
  assign push       = run_strobe && ((fifo_level_out < DEPTH_L) || pop);
  assign rd_nxt     = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign level_nxt  = fifo_level_out + {4'b0, push} - {4'b0, pop};

  // The head is registered, so a word written this cycle into the slot the
  // read pointer is about to land on must be forwarded straight from result_in.
  always_comb begin
    head_nxt = mem[rd_nxt];
    if (push && (wr_ptr == rd_nxt))
      head_nxt = result_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_level_out   <= '0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= result_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr           <= rd_nxt;
      fifo_level_out   <= level_nxt;
      result_valid_out <= (level_nxt != 5'd0);
      result_out       <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      continuous     <= 1'b0;
      remaining      <= '0;
      discard_cnt    <= '0;
      config_1_out   <= '0;
      core_rst_n_out <= 1'b0;
      busy_out       <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      if (run_strobe && !push)
        overflow_out <= 1'b1;

      case (state)
        IDLE: begin
          if (start_in) begin
            config_1_out   <= {10'b0, osr_mode_in, avg_control_in};
            continuous     <= continuous_in;
            remaining      <= (count_in == 8'd0) ? 9'd256 : {1'b0, count_in};
            discard_cnt    <= '0;
            overflow_out   <= 1'b0;
            core_rst_n_out <= 1'b1;
            busy_out       <= 1'b1;
            state          <= (DISCARD > 0) ? SETTLE : RUN;
          end
        end
        SETTLE: begin
          if (stop_in) begin
            core_rst_n_out <= 1'b0;
            state          <= STOP;
          end else if (conv_finished_in) begin
            discard_cnt <= discard_cnt + 2'd1;
            if (discard_cnt == DISC_LAST)
              state <= RUN;
          end
        end
        RUN: begin
          if (conv_finished_in && !continuous)
            remaining <= remaining - 9'd1;
          if (stop_in || (conv_finished_in && !continuous && remaining == 9'd1)) begin
            core_rst_n_out <= 1'b0;
            state          <= STOP;
          end
        end
        STOP: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Directed bench for adc_conversion_scheduler: a burst vector table plus
// hand-written sequences for 256-count, overflow, full push/pop, stop and reset.
module tb_adc_conversion_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_in, stop_in, continuous_in;
  logic [7:0]  count_in;
  logic [2:0]  avg_control_in, osr_mode_in;
  logic [15:0] config_1_out;
  logic        core_rst_n_out;
  logic        conv_finished_in;
  logic [15:0] result_in;
  logic [15:0] result_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic [4:0]  fifo_level_out;
  logic        busy_out;
  logic        overflow_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  adc_conversion_scheduler #(.FIFO_DEPTH(4), .DISCARD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_in(start_in), .stop_in(stop_in), .continuous_in(continuous_in),
    .count_in(count_in), .avg_control_in(avg_control_in), .osr_mode_in(osr_mode_in),
    .config_1_out(config_1_out), .core_rst_n_out(core_rst_n_out),
    .conv_finished_in(conv_finished_in), .result_in(result_in),
    .result_out(result_out), .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in), .fifo_level_out(fifo_level_out),
    .busy_out(busy_out), .overflow_out(overflow_out)
  );

  typedef struct {
    logic        start, stop, cont;
    logic [7:0]  count;
    logic [2:0]  avg, osr;
    logic        conv;
    logic [15:0] res;
    logic        ready;
    logic        e_crst, e_busy, e_valid;
    logic [15:0] e_rout;
    logic [4:0]  e_level;
    logic        e_ovf;
    logic [15:0] e_cfg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_in = 0; stop_in = 0; continuous_in = 0; count_in = 0;
    avg_control_in = 0; osr_mode_in = 0; conv_finished_in = 0; result_in = 0;
  endtask

  task automatic strobe(input logic [15:0] r);
    conv_finished_in = 1; result_in = r;
    step();
    conv_finished_in = 0;
  endtask

  task automatic start_run(input logic cont, input logic [7:0] cnt,
                           input logic [2:0] avg, input logic [2:0] osr);
    start_in = 1; continuous_in = cont; count_in = cnt;
    avg_control_in = avg; osr_mode_in = osr;
    step();
    idle_inputs();
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic [15:0] cv,
                              input logic cf, input logic [15:0] rs,
                              input logic ec, input logic eb, input logic ev,
                              input logic [15:0] er, input logic [4:0] el, input logic eo);
    vec_t v;
    v.start = st; v.stop = sp; v.cont = 1'b0;
    v.count = cv[7:0]; v.avg = cv[10:8]; v.osr = cv[14:12];
    v.conv = cf; v.res = rs; v.ready = 1'b1;
    v.e_crst = ec; v.e_busy = eb; v.e_valid = ev; v.e_rout = er;
    v.e_level = el; v.e_ovf = eo; v.e_cfg = 16'h002A;
    return v;
  endfunction

  initial begin
    // burst: count 3, avg 2, osr 5 packed as {osr,avg,count} in the cv argument
    vecs[0] = mk(1, 0, 16'h5203, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0);
    vecs[1] = mk(0, 0, 16'h0000, 1, 16'h0100, 1, 1, 0, 16'h0000, 0, 0);
    vecs[2] = mk(0, 0, 16'h0000, 1, 16'h0101, 1, 1, 1, 16'h0101, 1, 0);
    vecs[3] = mk(0, 0, 16'h0000, 1, 16'h0102, 1, 1, 1, 16'h0102, 1, 0);
    vecs[4] = mk(0, 0, 16'h0000, 1, 16'h0103, 0, 1, 1, 16'h0103, 1, 0);
    vecs[5] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    vecs[6] = mk(0, 0, 16'h0000, 1, 16'h01FF, 0, 0, 0, 16'h0000, 0, 0);
    vecs[7] = mk(0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

    idle_inputs();
    result_ready_in = 0;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_cfg", config_1_out, 0);
    chk("rst_core_rst", core_rst_n_out, 0);
    chk("rst_valid", result_valid_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_level", fifo_level_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_ovf", overflow_out, 0);
    step();
    rst_n = 1;
    step();

    for (int i = 0; i < 8; i++) begin
      start_in = vecs[i].start; stop_in = vecs[i].stop; continuous_in = vecs[i].cont;
      count_in = vecs[i].count; avg_control_in = vecs[i].avg; osr_mode_in = vecs[i].osr;
      conv_finished_in = vecs[i].conv; result_in = vecs[i].res;
      result_ready_in = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_core_rst", i), core_rst_n_out, vecs[i].e_crst);
      chk($sformatf("vec%0d_busy", i), busy_out, vecs[i].e_busy);
      chk($sformatf("vec%0d_valid", i), result_valid_out, vecs[i].e_valid);
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_result", i), result_out, vecs[i].e_rout);
      chk($sformatf("vec%0d_level", i), fifo_level_out, vecs[i].e_level);
      chk($sformatf("vec%0d_ovf", i), overflow_out, vecs[i].e_ovf);
      chk($sformatf("vec%0d_cfg", i), config_1_out, vecs[i].e_cfg);
    end
    idle_inputs();

    // count_in = 0 -> 256 accepted strobes
    result_ready_in = 1;
    start_run(0, 8'd0, 3'd0, 3'd0);
    strobe(16'h0000);
    for (int i = 1; i <= 256; i++) begin
      strobe(16'(i));
      if (i == 255) chk("cnt256_still_run", core_rst_n_out, 1);
      if (i == 256) chk("cnt256_stop", core_rst_n_out, 0);
    end
    step();
    chk("cnt256_idle_busy", busy_out, 0);
    chk("cnt256_level", fifo_level_out, 0);

    // overflow: ready low, burst of 6 into a 4-deep FIFO
    result_ready_in = 0;
    start_run(0, 8'd6, 3'd0, 3'd0);
    strobe(16'h0200);
    for (int i = 1; i <= 6; i++) strobe(16'h0200 + 16'(i));
    step();
    chk("ovf_level", fifo_level_out, 4);
    chk("ovf_flag", overflow_out, 1);
    chk("ovf_busy", busy_out, 0);
    result_ready_in = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d_valid", i), result_valid_out, 1);
      chk($sformatf("ovf_pop%0d_data", i), result_out, 16'h0200 + 16'(i));
      step();
    end
    chk("ovf_drained_valid", result_valid_out, 0);
    chk("ovf_drained_level", fifo_level_out, 0);
    chk("ovf_sticky", overflow_out, 1);

    // continuous: full FIFO with push+pop in one cycle, then stop on a strobe
    result_ready_in = 0;
    start_run(1, 8'd1, 3'd1, 3'd3);
    chk("cont_ovf_cleared", overflow_out, 0);
    strobe(16'h0300);
    for (int i = 1; i <= 4; i++) strobe(16'h0300 + 16'(i));
    chk("full_level", fifo_level_out, 4);
    result_ready_in = 1;
    strobe(16'h0305);
    chk("full_pp_level", fifo_level_out, 4);
    chk("full_pp_ovf", overflow_out, 0);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("full_order%0d", i), result_out, 16'h0300 + 16'(i));
      step();
    end
    chk("full_empty", fifo_level_out, 0);
    chk("cont_still_run", core_rst_n_out, 1);
    result_ready_in = 0;
    stop_in = 1;
    strobe(16'h0307);
    stop_in = 0;
    chk("stop_stored_level", fifo_level_out, 1);
    chk("stop_stored_data", result_out, 16'h0307);
    chk("stop_core_rst", core_rst_n_out, 0);
    chk("stop_busy", busy_out, 1);
    start_in = 1; avg_control_in = 3'd7; osr_mode_in = 3'd7;
    step();
    idle_inputs();
    chk("stop_start_busy", busy_out, 0);
    step();
    chk("stop_start_ignored_busy", busy_out, 0);
    chk("stop_start_ignored_crst", core_rst_n_out, 0);
    chk("stop_start_ignored_cfg", config_1_out, 16'h0019);
    result_ready_in = 1;
    step();
    chk("stop_popped", fifo_level_out, 0);

    // asynchronous reset mid-run with two entries held
    result_ready_in = 0;
    start_run(0, 8'd10, 3'd4, 3'd6);
    strobe(16'h0400);
    strobe(16'h0401);
    strobe(16'h0402);
    chk("mr_level", fifo_level_out, 2);
    chk("mr_crst", core_rst_n_out, 1);
    #3 rst_n = 0;
    #1;
    chk("mr_cfg", config_1_out, 0);
    chk("mr_core_rst", core_rst_n_out, 0);
    chk("mr_valid", result_valid_out, 0);
    chk("mr_result", result_out, 0);
    chk("mr_level0", fifo_level_out, 0);
    chk("mr_busy", busy_out, 0);
    chk("mr_ovf", overflow_out, 0);
    step();
    rst_n = 1;
    step();
    chk("mr_after_level", fifo_level_out, 0);
    chk("mr_after_busy", busy_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
